// File: rtl/rd_stream_adapter.sv
// rd_stream_adapter
//   Turns the read side of an async FIFO (empty flag + combinational read
//   data) into a valid/ready stream. A 2-entry skid buffer decouples the pop
//   request from downstream backpressure, so rinc never depends
//   combinationally on m_ready, and full throughput is kept.
//
// Ports
//   r_clk      read-domain clock, rising edge
//   r_rst      asynchronous active-low reset
//   rempty     FIFO empty flag (r_clk domain)
//   rdata      FIFO read data at current raddr, valid in the same cycle
//   rinc       pop request to the read controller
//   m_valid    output stream word valid (registered)
//   m_data     output stream word (registered head entry)
//   m_ready    downstream accepts word
//   occupancy  number of words held in the skid buffer, 0..2
//   xfer_cnt   16-bit wrapping count of completed takes; present only
//              when RD_STREAM_XFER_CNT_EN is defined
//
// Build option: `define RD_STREAM_XFER_CNT_EN to add the xfer_cnt port.

module rd_stream_adapter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            occupancy
`ifdef RD_STREAM_XFER_CNT_EN
    ,
    output logic [15:0]           xfer_cnt
`endif
);

    logic [DATA_WIDTH-1:0] head_q, tail_q;
    logic [DATA_WIDTH-1:0] head_d, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  guard_q;
    logic                  pop;
    logic                  take;

    // The read controller reports "not empty" straight out of reset, so the
    // guard blocks the very first pop request after reset release.
    assign rinc      = ~rempty & (count_q < 2'd2) & ~guard_q;
    assign pop       = rinc & ~rempty;
    assign m_valid   = (count_q != 2'd0);
    assign take      = m_valid & m_ready;
    assign m_data    = head_q;
    assign occupancy = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (pop) begin
                    head_d  = rdata;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                // Simultaneous pop and take: the new word replaces the head.
                if (pop && take) begin
                    head_d = rdata;
                end else if (pop) begin
                    tail_d  = rdata;
                    count_d = 2'd2;
                end else if (take) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // rinc is low when full, so only a take can happen here.
                if (take) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            guard_q <= 1'b1;
        end else begin
            guard_q <= 1'b0;
        end
    end

`ifdef RD_STREAM_XFER_CNT_EN
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            xfer_cnt <= '0;
        end else if (take) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rd_stream_adapter.sv
// tb_rd_stream_adapter
//   Self-checking bench for rd_stream_adapter. A queue-based model of the
//   skid buffer predicts m_valid, m_data, occupancy, rinc (and xfer_cnt when
//   RD_STREAM_XFER_CNT_EN is defined); directed scenarios add literal
//   expectations, followed by randomized traffic with occasional resets.

module tb_rd_stream_adapter;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b0;
    logic       rempty = 1'b1;
    logic [7:0] rdata = '0;
    logic       rinc;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic [1:0] occupancy;
`ifdef RD_STREAM_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    rd_stream_adapter #(.DATA_WIDTH(8)) dut (
        .r_clk     (r_clk),
        .r_rst     (r_rst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .occupancy (occupancy)
`ifdef RD_STREAM_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 r_clk = ~r_clk;

    // Reference model: buffered words in arrival order, first-cycle guard,
    // and a wrapping take counter.
    logic [7:0]  q[$];
    bit          m_guard = 1'b1;
    logic [15:0] xfer_m = '0;
    int          takes_m = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs after the falling edge and compare outputs to the model.
    task automatic drive(input logic re, input logic [7:0] rd, input logic rdy);
        @(negedge r_clk);
        rempty  = re;
        rdata   = rd;
        m_ready = rdy;
        #1;
        check("m_valid", {31'd0, m_valid}, {31'd0, q.size() != 0});
        check("occupancy", {30'd0, occupancy}, q.size());
        check("rinc", {31'd0, rinc}, {31'd0, (!m_guard && !re && q.size() < 2)});
        if (q.size() != 0)
            check("m_data", {24'd0, m_data}, {24'd0, q[0]});
`ifdef RD_STREAM_XFER_CNT_EN
        check("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, xfer_m});
`endif
    endtask

    // Advance one clock and update the model with what that edge does.
    task automatic tick();
        bit         pop;
        bit         take;
        logic [7:0] d;
        pop  = !m_guard && !rempty && (q.size() < 2);
        take = (q.size() != 0) && m_ready;
        d    = rdata;
        @(posedge r_clk);
        if (take) begin
            void'(q.pop_front());
            xfer_m = xfer_m + 16'd1;
            takes_m++;
        end
        if (pop)
            q.push_back(d);
        m_guard = 1'b0;
    endtask

    // Reset asserted and released mid-cycle, away from any clock edge.
    task automatic do_reset();
        @(posedge r_clk);
        #3;
        r_rst = 1'b0;
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_occupancy", {30'd0, occupancy}, 32'd0);
        check("rst_rinc", {31'd0, rinc}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
`ifdef RD_STREAM_XFER_CNT_EN
        check("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
`endif
        q.delete();
        m_guard = 1'b1;
        xfer_m  = '0;
        takes_m = 0;
        @(posedge r_clk);
        @(posedge r_clk);
        #3;
        r_rst = 1'b1;
    endtask

    initial begin
        do_reset();

        // First cycle after release is guarded, the second pops, the word
        // appears one cycle later.
        drive(1'b0, 8'h11, 1'b0);
        check("first_cycle_rinc", {31'd0, rinc}, 32'd0);
        tick();
        drive(1'b0, 8'h11, 1'b0);
        check("second_cycle_rinc", {31'd0, rinc}, 32'd1);
        tick();
        drive(1'b1, 8'h22, 1'b0);
        check("first_word_valid", {31'd0, m_valid}, 32'd1);
        check("first_word_data", {24'd0, m_data}, 32'h11);
        tick();
        drive(1'b1, 8'h00, 1'b1);
        tick();

        // Back-to-back stream at one word per cycle.
        for (int unsigned i = 1; i <= 8; i++) begin
            drive(1'b0, 8'(i), 1'b1);
            if (i >= 2) begin
                check("stream_data", {24'd0, m_data}, i - 1);
                check("stream_occupancy", {30'd0, occupancy}, 32'd1);
            end
            tick();
        end
        drive(1'b1, 8'h00, 1'b1);
        check("stream_last", {24'd0, m_data}, 32'h08);
        tick();

        // Backpressure fills both entries; the head holds until released.
        drive(1'b0, 8'hA0, 1'b0);
        tick();
        drive(1'b0, 8'hA1, 1'b0);
        tick();
        for (int unsigned k = 0; k < 2; k++) begin
            drive(1'b0, 8'hA2, 1'b0);
            check("full_occupancy", {30'd0, occupancy}, 32'd2);
            check("full_rinc", {31'd0, rinc}, 32'd0);
            check("full_hold", {24'd0, m_data}, 32'hA0);
            tick();
        end
        drive(1'b1, 8'h00, 1'b1);
        check("drain_first", {24'd0, m_data}, 32'hA0);
        tick();
        drive(1'b0, 8'hB0, 1'b1);
        check("drain_second", {24'd0, m_data}, 32'hA1);
        check("rinc_reassert", {31'd0, rinc}, 32'd1);
        tick();
        drive(1'b1, 8'h00, 1'b1);
        tick();
        drive(1'b1, 8'h00, 1'b1);
        tick();

        // Pop and take together at count 1: the new word becomes head.
        drive(1'b0, 8'h55, 1'b0);
        tick();
        drive(1'b0, 8'h66, 1'b1);
        check("swap_before", {24'd0, m_data}, 32'h55);
        tick();
        drive(1'b1, 8'h00, 1'b0);
        check("swap_data", {24'd0, m_data}, 32'h66);
        check("swap_occupancy", {30'd0, occupancy}, 32'd1);
        tick();

        // Reset while full discards everything.
        drive(1'b0, 8'h77, 1'b0);
        tick();
        drive(1'b1, 8'h00, 1'b0);
        check("pre_reset_full", {30'd0, occupancy}, 32'd2);
        do_reset();
        drive(1'b1, 8'h00, 1'b1);
        check("post_reset_empty", {31'd0, m_valid}, 32'd0);
        tick();
        drive(1'b1, 8'h00, 1'b1);
        check("post_reset_no_stale", {31'd0, m_valid}, 32'd0);
        tick();

        // Randomized traffic with shifting bias and occasional resets.
        begin
            int unsigned empty_pct;
            int unsigned ready_pct;
            empty_pct = 30;
            ready_pct = 70;
            for (int unsigned c = 0; c < 3000; c++) begin
                if (c % 100 == 0) begin
                    empty_pct = $urandom_range(0, 80);
                    ready_pct = $urandom_range(10, 100);
                end
                if ($urandom_range(0, 299) == 0)
                    do_reset();
                drive($urandom_range(0, 99) < empty_pct,
                      8'($urandom),
                      $urandom_range(0, 99) < ready_pct);
                tick();
            end
        end

`ifdef RD_STREAM_XFER_CNT_EN
        // 65537 takes wrap the 16-bit counter to 1.
        do_reset();
        begin
            int unsigned guard_cycles;
            guard_cycles = 0;
            while (takes_m < 65537 && guard_cycles < 70000) begin
                drive(1'b0, 8'(guard_cycles), (takes_m < 65536) || (q.size() != 0 && takes_m == 65536));
                tick();
                guard_cycles++;
            end
            drive(1'b1, 8'h00, 1'b0);
            check("wrap_takes", takes_m, 32'd65537);
            check("xfer_wrap", {16'd0, xfer_cnt}, 32'd1);
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rd_stream_adapter.md
RD_STREAM_ADAPTER -- requirements
Module: rd_stream_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO read data and output stream data.
REQ-002 Port r_clk  input  1  read-domain clock; all state updates on rising edge.
REQ-003 Port r_rst  input  1  asynchronous active-low reset.
REQ-004 Port rempty  input  1  FIFO empty flag from read controller, r_clk domain.
REQ-005 Port rdata  input  DATA_WIDTH  FIFO memory read data at current raddr; combinational, valid in the same cycle.
REQ-006 Port rinc  output  1  pop request to read controller.
REQ-007 Port m_valid  output  1  output stream word valid.
REQ-008 Port m_data  output  DATA_WIDTH  output stream word.
REQ-009 Port m_ready  input  1  downstream accepts word.
REQ-010 Port occupancy  output  2  number of words held in the skid buffer, 0..2.

Function
REQ-011 Block SHALL hold a 2-entry FIFO-ordered skid buffer (head, tail) plus a 2-bit count.
REQ-012 pop SHALL be defined as rinc & ~rempty; a word is captured from rdata only on pop.
REQ-013 rinc SHALL equal ~rempty & (count < 2) & ~guard; rinc SHALL NOT depend combinationally on m_ready.
REQ-014 On pop, rdata SHALL be written to the first free entry at the r_clk edge.
REQ-015 take SHALL be defined as m_valid & m_ready; on take, head SHALL be removed and tail, if present, SHALL move to head.
REQ-016 m_valid SHALL equal (count != 0); m_data SHALL equal head entry; both driven from registers only.
REQ-017 Latency: a word popped in cycle N SHALL appear on m_data with m_valid high in cycle N+1.
REQ-018 While m_valid & ~m_ready, m_data SHALL remain stable and m_valid SHALL remain high.
REQ-019 Count update: pop & ~take -> +1; take & ~pop -> -1; both or neither -> unchanged.
REQ-020 At count 1 with simultaneous pop and take, the new word SHALL become head in the next cycle.
REQ-021 At count 2, rinc SHALL be 0; no word lost, no overwrite.
REQ-022 At count 0, take cannot occur; m_ready high with m_valid low SHALL have no effect.
REQ-023 With continuous ~rempty and m_ready high, throughput SHALL be one word per cycle after the first word.
REQ-024 rempty rising while rinc high: pop is 0 by definition; no capture.
REQ-025 occupancy SHALL equal count.

Reset
REQ-026 On r_rst low: count=0, head=tail=0, m_valid=0, m_data=0, rinc=0, occupancy=0, immediately and asynchronously.
REQ-027 A 1-bit guard register SHALL reset to 1 and clear on the first r_clk edge after r_rst deasserts, suppressing rinc for that first cycle (read controller empty flag is 0 out of reset).
REQ-028 Reset asserted mid-transfer SHALL discard buffered words; no partial state survives.

Configuration
REQ-029 Macro RD_STREAM_XFER_CNT_EN SHALL, when defined, add port xfer_cnt  output  16  count of completed takes.
REQ-030 With macro defined: xfer_cnt resets to 0, increments by 1 on each take, wraps 0xFFFF -> 0x0000.
REQ-031 Without macro: port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset release, rempty=0, rdata=0x11 -> rinc=0 in first cycle, rinc=1 in second cycle, m_valid=1 with m_data=0x11 one cycle later.
REQ-033 Stream 0x01..0x08, m_ready=1 constant -> m_data sequence 0x01..0x08 on consecutive cycles, occupancy stays 1.
REQ-034 m_ready=0, rempty=0, words 0xA0,0xA1 -> occupancy=2, rinc=0, m_data held 0xA0; m_ready=1 -> 0xA0 then 0xA1, rinc reasserts.
REQ-035 count=1 (head 0x55), pop 0x66 and take same cycle -> next cycle m_data=0x66, occupancy=1.
REQ-036 r_rst pulsed low with occupancy=2 -> m_valid=0, occupancy=0 immediately; no stale word after release.
REQ-037 With RD_STREAM_XFER_CNT_EN, 65537 takes -> xfer_cnt=1; without macro, design elaborates without xfer_cnt.
